axis_ingress_rx: RTL and testbench
==================================

// Module: axis_ingress_rx
// PURPOSE
//  AXI-Stream receiver at the accelerator end of the DMA->ASIC stream (sm_* out of DMA_Controller).
//  Accepts one frame per ap_start, buffers beats in a FWFT FIFO and hands them to the compute core
//  over valid/ready. Reports idle/done status back to the DMA and flags frames whose length is wrong.
// PARAMETERS
//  DW     32  stream data width (bits)
//  DEPTH  8   FIFO depth in beats; power of two, >=2
//  LENW   16  width of frame_len and beat_cnt
// PORTS
//  clk         in   1     system clock (wb_clk_i domain)
//  rst         in   1     synchronous reset, active-low
//  ss_tvalid   in   1     stream beat valid (from DMA sm_tvalid)
//  ss_tdata    in   DW    stream beat data
//  ss_tlast    in   1     last beat of frame
//  ss_tready   out  1     receiver can accept a beat
//  core_valid  out  1     FIFO head valid toward core
//  core_data   out  DW    FIFO head data
//  core_last   out  1     FIFO head is the frame's final beat
//  core_ready  in   1     core consumes head this cycle
//  ap_start    in   1     1-cycle pulse: arm reception of one frame
//  frame_len   in   LENW  expected beats, sampled on ap_start; 0 = unbounded
//  ap_idle     out  1     receiver in IDLE
//  ap_done     out  1     1-cycle pulse: final beat consumed by core
//  beat_cnt    out  LENW  beats accepted in current/last frame
//  err_len     out  1     sticky length error, cleared by next ap_start
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state IDLE, FIFO empty, ss_tready=0, core_valid=0, core_data=0,
//   core_last=0, ap_idle=1, ap_done=0, beat_cnt=0, err_len=0. Reset mid-frame discards all buffered beats.
//  Beat accepted when ss_tvalid && ss_tready; data visible on core_valid the next cycle (latency 1).
//  ss_tready = (state==RECV) && !fifo_full; registered-state only, never depends on ss_tvalid.
//  Pop when core_valid && core_ready. Push+pop same cycle: occupancy unchanged. Full: ss_tready=0,
//   so no push even if core pops that cycle. Empty: core_valid=0, core_data holds last popped value.
//  Pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH)+1 bits.
//  FSM:
//   IDLE : ap_idle=1. ap_start -> latch frame_len, beat_cnt=0, err_len=0 -> RECV.
//   RECV : accept beats, beat_cnt++ per beat (saturates at all-ones). Beat with tlast (or forced last)
//          is pushed with last flag -> DRAIN.
//   DRAIN: ss_tready=0; wait for pop of the last-flagged beat -> DONE.
//   DONE : ap_done=1 for exactly one cycle -> IDLE.
//  ap_start outside IDLE is ignored. ss_tvalid outside RECV is back-pressured (no beat lost).
//  Beats of one frame never mix with the next: a new frame can only start after DONE.
// CONFIGURATION
//  AXIS_RX_LEN_CHECK_EN defined:
//   - tlast on beat N != latched frame_len (frame_len!=0) -> err_len=1, frame ends normally.
//   - beat frame_len accepted without tlast -> beat forced to core_last=1, err_len=1, -> DRAIN;
//     DMA's remaining beats stay back-pressured until next ap_start.
//  Not defined: frame_len ignored, only ss_tlast ends a frame, err_len tied to 0.
// STRUCTURE
//  Package axis_rx_pkg: state enum {IDLE,RECV,DRAIN,DONE}, default DW/DEPTH/LENW constants.
//  Sub-module axis_rx_fifo: FWFT sync FIFO of width DW+1 (data+last), push/pop/full/empty/count.
//  Top holds FSM, beat counter and length check.
// TESTING
//  1 Reset: drive rst=0 two cycles with ss_tvalid=1 -> ss_tready=0, ap_idle=1, all outputs as listed.
//  2 ap_start frame_len=4, beats 0xA0..0xA3 tlast on 4th, core_ready=1 -> same order on core_data
//    one cycle later, core_last on 0xA3, ap_done pulse one cycle after its pop, beat_cnt=4, err_len=0.
//  3 DEPTH=8, core_ready=0, 12-beat frame -> ss_tready drops after 8 accepts; release core_ready ->
//    all 12 beats delivered in order, none lost or duplicated.
//  4 LEN_CHECK_EN, frame_len=4, tlast on beat 3 -> err_len=1, ap_done after beat 3, beat_cnt=3.
//  5 LEN_CHECK_EN, frame_len=4, 6 beats no tlast -> beat 4 has core_last=1, err_len=1, beats 5-6
//    held (ss_tready=0); next ap_start clears err_len and accepts beat 5 as new frame's first.
//  6 rst asserted in RECV with 3 beats buffered -> FIFO empty, core_valid=0, ap_idle=1 next cycle.

Source files
------------

// File: rtl/axis_rx_pkg.sv
// Shared types and defaults for the AXI-Stream ingress receiver.
// Optional length check is enabled by defining AXIS_RX_LEN_CHECK_EN.
package axis_rx_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 8;
  localparam int LENW_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DRAIN,
    DONE
  } rx_state_e;

endpackage

// File: rtl/axis_ingress_rx_if.sv
// Stream-in (ss_*) and core-out (core_*) handshake bundle.
// slave: receiver side; master: DMA/core side.
interface axis_ingress_rx_if
  import axis_rx_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          ss_tvalid;
  logic [DW-1:0] ss_tdata;
  logic          ss_tlast;
  logic          ss_tready;
  logic          core_valid;
  logic [DW-1:0] core_data;
  logic          core_last;
  logic          core_ready;

  modport slave (
    input  ss_tvalid, ss_tdata, ss_tlast,
    output ss_tready,
    output core_valid, core_data, core_last,
    input  core_ready
  );

  modport master (
    output ss_tvalid, ss_tdata, ss_tlast,
    input  ss_tready,
    input  core_valid, core_data, core_last,
    output core_ready
  );
endinterface

// File: rtl/axis_rx_fifo.sv
// First-word-fall-through sync FIFO; dout holds last popped word when empty.
// Ports: clk, rst (sync, active-low), push/din, pop/dout, full, empty, count.
module axis_rx_fifo
  import axis_rx_pkg::*;
#(
  parameter int W     = DW_DEF + 1,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  hold;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? hold : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/axis_ingress_rx.sv
// One-frame-per-ap_start AXI-Stream receiver feeding a compute core via FIFO.
// Ports: clk, rst, bus (ss_*/core_*), ap_start, frame_len, ap_idle, ap_done,
// beat_cnt, err_len. Define AXIS_RX_LEN_CHECK_EN to enforce frame_len.
module axis_ingress_rx
  import axis_rx_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LENW  = LENW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  axis_ingress_rx_if.slave    bus,
  input  logic                ap_start,
  input  logic [LENW-1:0]     frame_len,
  output logic                ap_idle,
  output logic                ap_done,
  output logic [LENW-1:0]     beat_cnt,
  output logic                err_len
);
  rx_state_e state, state_nx;

  logic                   rx_ready;
  logic                   accept;
  logic                   head_pop;
  logic                   push_last;
  logic                   force_last;
  logic                   len_bad;
  logic [LENW-1:0]        cnt_nx;
  logic [DW:0]            head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] unused_occ;

  assign rx_ready  = (state == RECV) && !fifo_full;
  assign accept    = bus.ss_tvalid && rx_ready;
  assign head_pop  = !fifo_empty && bus.core_ready;
  assign cnt_nx    = &beat_cnt ? beat_cnt : beat_cnt + 1'b1;
  assign push_last = bus.ss_tlast || force_last;

`ifdef AXIS_RX_LEN_CHECK_EN
  logic [LENW-1:0] len_q;
  logic            len_on;

  assign len_on     = |len_q;
  // Reaching the expected count without tlast closes the frame here.
  assign force_last = len_on && !bus.ss_tlast && cnt_nx == len_q;
  assign len_bad    = len_on && bus.ss_tlast && cnt_nx != len_q;

  always_ff @(posedge clk) begin
    if (!rst) len_q <= '0;
    else if (state == IDLE && ap_start) len_q <= frame_len;
  end
`else
  logic unused_len;

  assign unused_len = ^frame_len;
  assign force_last = 1'b0;
  assign len_bad    = 1'b0;
`endif

  axis_rx_fifo #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   ({push_last, bus.ss_tdata}),
    .pop   (bus.core_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_occ)
  );

  assign bus.ss_tready  = rx_ready;
  assign bus.core_valid = !fifo_empty;
  assign bus.core_data  = head[DW-1:0];
  assign bus.core_last  = !fifo_empty && head[DW];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ap_idle  = 1'b0;
    ap_done  = 1'b0;
    unique case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_nx = RECV;
      end
      RECV: begin
        if (accept && push_last) state_nx = DRAIN;
      end
      DRAIN: begin
        // Only this frame's final beat carries the last flag.
        if (head_pop && head[DW]) state_nx = DONE;
      end
      DONE: begin
        ap_done  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt <= '0;
      err_len  <= 1'b0;
    end else if (state == IDLE && ap_start) begin
      beat_cnt <= '0;
      err_len  <= 1'b0;
    end else if (accept) begin
      beat_cnt <= cnt_nx;
      if (len_bad || force_last) err_len <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_ingress_rx.sv
// Scoreboard bench for axis_ingress_rx: random stream/core handshakes
// against a frame-level reference model; AXIS_RX_LEN_CHECK_EN aware.
module tb_axis_ingress_rx;
  import axis_rx_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LENW  = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int cnt;
    bit err;
  } stat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ap_start = 1'b0;
  logic [LENW-1:0] frame_len = '0;
  logic            ap_idle;
  logic            ap_done;
  logic [LENW-1:0] beat_cnt;
  logic            err_len;

  axis_ingress_rx_if #(.DW(DW)) bus ();

  axis_ingress_rx #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .LENW  (LENW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .ap_start  (ap_start),
    .frame_len (frame_len),
    .ap_idle   (ap_idle),
    .ap_done   (ap_done),
    .beat_cnt  (beat_cnt),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  beat_t src_q[$];
  beat_t exp_q[$];
  stat_t stat_q[$];
  beat_t mon_e;
  stat_t mon_s;

  int vectors     = 0;
  int miscompares = 0;
  int accepts     = 0;
  int done_cnt    = 0;
  bit force_valid = 1'b0;
  bit rnd_valid   = 1'b1;
  int ready_mode  = 2;
  bit prev_last   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream source: presents src_q head, retires it on handshake.
  initial begin
    bus.ss_tvalid = 1'b0;
    bus.ss_tdata  = '0;
    bus.ss_tlast  = 1'b0;
    forever begin
      @(posedge clk);
      if (bus.ss_tvalid && bus.ss_tready && !force_valid) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        accepts++;
      end
      #1;
      if (force_valid) begin
        bus.ss_tvalid = 1'b1;
        bus.ss_tdata  = 32'hDEAD;
        bus.ss_tlast  = 1'b1;
      end else if (src_q.size() > 0 &&
                   (!rnd_valid || $urandom_range(0, 3) != 0)) begin
        bus.ss_tvalid = 1'b1;
        bus.ss_tdata  = src_q[0].data;
        bus.ss_tlast  = src_q[0].last;
      end else begin
        bus.ss_tvalid = 1'b0;
        bus.ss_tdata  = $urandom;
        bus.ss_tlast  = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    bus.core_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.core_ready = 1'($urandom_range(0, 1));
        1:       bus.core_ready = 1'b1;
        default: bus.core_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expectations whenever the core takes a beat or done fires.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_last = 1'b0;
      end else begin
        if (bus.core_valid && bus.core_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %0h expected none",
                     bus.core_data);
          end else begin
            mon_e = exp_q.pop_front();
            chk("core_data", 64'(bus.core_data), 64'(mon_e.data));
            chk("core_last", 64'(bus.core_last), 64'(mon_e.last));
          end
        end
        if (ap_done || prev_last)
          chk("ap_done_timing", 64'(ap_done), 64'(prev_last));
        if (ap_done) begin
          done_cnt++;
          if (stat_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got 1 expected 0");
          end else begin
            mon_s = stat_q.pop_front();
            chk("beat_cnt", 64'(beat_cnt), 64'(mon_s.cnt));
            chk("err_len", 64'(err_len), 64'(mon_s.err));
          end
        end
        prev_last = bus.core_valid && bus.core_ready && bus.core_last;
      end
    end
  end

  task automatic wait_idle();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (ap_idle) return;
    end
    chk("idle_timeout", 64'(ap_idle), 64'd1);
  endtask

  // Reference model: a frame is the src_q prefix up to the first tlast,
  // or up to frame_len beats when the length check is built in.
  task automatic start_frame(input int flen);
    int k;
    bit err;
    bit fin;
    wait_idle();
    k   = 0;
    err = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < src_q.size() && !fin; i++) begin
      k = i + 1;
      if (src_q[i].last) begin
        fin = 1'b1;
`ifdef AXIS_RX_LEN_CHECK_EN
        err = (flen != 0) && (k != flen);
`endif
      end
`ifdef AXIS_RX_LEN_CHECK_EN
      else if (flen != 0 && k == flen) begin
        fin = 1'b1;
        err = 1'b1;
      end
`endif
    end
    for (int i = 0; i < k; i++)
      exp_q.push_back('{data: src_q[i].data, last: (i == k - 1)});
    stat_q.push_back('{cnt: k, err: err});
    @(posedge clk);
    #1;
    ap_start  = 1'b1;
    frame_len = LENW'(flen);
    @(posedge clk);
    #1;
    ap_start  = 1'b0;
    frame_len = LENW'($urandom);
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (done_cnt != d0) return;
    end
    chk("done_timeout", 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic push_frame(input logic [DW-1:0] base, input int n,
                            input int last_at);
    for (int i = 0; i < n; i++)
      src_q.push_back('{data: base + DW'(i), last: (i == last_at)});
  endtask

  initial begin
    int a0;
    int n;
    int flen;
    bit seen;

    // Reset with a valid beat pending
    rst         = 1'b0;
    force_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 64'(bus.ss_tready), 64'd0);
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_cvalid", 64'(bus.core_valid), 64'd0);
    chk("rst_cdata", 64'(bus.core_data), 64'd0);
    chk("rst_clast", 64'(bus.core_last), 64'd0);
    chk("rst_done", 64'(ap_done), 64'd0);
    chk("rst_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_err", 64'(err_len), 64'd0);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    force_valid = 1'b0;

    // Basic 4-beat frame with latency check
    rnd_valid  = 1'b0;
    ready_mode = 1;
    push_frame(32'hA0, 4, 3);
    start_frame(4);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.ss_tvalid && bus.ss_tready) seen = 1'b1;
    end
    chk("lat_seen", 64'(seen), 64'd1);
    chk("lat_pre_valid", 64'(bus.core_valid), 64'd0);
    @(negedge clk);
    chk("lat_post_valid", 64'(bus.core_valid), 64'd1);
    chk("lat_post_data", 64'(bus.core_data), 64'hA0);
    wait_done();

    // Backpressure: FIFO fills at DEPTH beats
    ready_mode = 2;
    push_frame(32'hB00, 12, 11);
    a0 = accepts;
    start_frame(12);
    repeat (25) @(negedge clk);
    chk("full_accepts", 64'(accepts - a0), 64'(DEPTH));
    chk("full_tready", 64'(bus.ss_tready), 64'd0);
    ready_mode = 1;
    wait_done();

`ifdef AXIS_RX_LEN_CHECK_EN
    // Early tlast against frame_len=4
    push_frame(32'hC0, 3, 2);
    start_frame(4);
    wait_done();

    // Missing tlast: beat 4 forced last, beats 5-6 held
    push_frame(32'hD0, 6, -1);
    start_frame(4);
    wait_done();
    wait_idle();
    repeat (3) @(negedge clk);
    chk("held_beats", 64'(src_q.size()), 64'd2);
    chk("held_tready", 64'(bus.ss_tready), 64'd0);
    src_q.push_back('{data: 32'hD6, last: 1'b1});
    start_frame(0);
    @(negedge clk);
    chk("err_cleared", 64'(err_len), 64'd0);
    wait_done();
`endif

    // Reset mid-frame with beats buffered
    ready_mode = 2;
    push_frame(32'hE0, 6, 5);
    a0 = accepts;
    start_frame(0);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (accepts - a0 >= 3) seen = 1'b1;
    end
    chk("mid_buffered", 64'(bus.core_valid), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_cvalid", 64'(bus.core_valid), 64'd0);
    chk("mid_idle", 64'(ap_idle), 64'd1);
    chk("mid_tready", 64'(bus.ss_tready), 64'd0);
    exp_q.delete();
    stat_q.delete();
    src_q.delete();
    rst = 1'b1;

    // Random frames and handshakes
    ready_mode = 0;
    rnd_valid  = 1'b1;
    repeat (40) begin
      n = $urandom_range(1, 10);
      push_frame(DW'($urandom), n, n - 1);
      case ($urandom_range(0, 2))
        0:       flen = 0;
        1:       flen = n;
        default: flen = $urandom_range(1, 12);
      endcase
      start_frame(flen);
      wait_done();
    end
    if (src_q.size() > 0) begin
      start_frame(0);
      wait_done();
    end
    repeat (5) @(negedge clk);
    chk("exp_left", 64'(exp_q.size()), 64'd0);
    chk("stat_left", 64'(stat_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
